date_edit_ctrl: RTL and testbench

- Sequences the date display overlay in programming mode.
- Captures the RTC date (day/month/year, packed BCD) on entry to programming mode and moves the edit cursor between the three fields (screen addresses 3/4/5).
- Applies BCD increment/decrement with calendar limits, and commits the edited date back to the RTC writer through a req/ack handshake.
- Its outputs drive the overlay's date inputs and its current-screen-address input.

---
 rtl/date_edit_pkg.sv | 46 ++++
 rtl/date_edit_ctrl_if.sv | 34 +++
 rtl/bcd_max_day.sv | 31 +++
 rtl/date_edit_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_date_edit_ctrl.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/date_edit_pkg.sv
// Shared types, screen addresses, reset date and BCD wrap helpers for the date editor.
package date_edit_pkg;

   localparam int unsigned DATE_W = 8;
   localparam int unsigned ADDR_W = 4;

   typedef enum logic [1:0] {IDLE, LOAD, EDIT, COMMIT} state_t;

   localparam logic [ADDR_W-1:0] ADDR_NONE  = 4'd0;
   localparam logic [ADDR_W-1:0] ADDR_DAY   = 4'd3;
   localparam logic [ADDR_W-1:0] ADDR_MONTH = 4'd4;
   localparam logic [ADDR_W-1:0] ADDR_YEAR  = 4'd5;

   localparam logic [DATE_W-1:0] RST_DAY   = 8'h01;
   localparam logic [DATE_W-1:0] RST_MONTH = 8'h01;
   localparam logic [DATE_W-1:0] RST_YEAR  = 8'h00;

   // Values at or above max (including out-of-range loads) wrap to min.
   function automatic logic [DATE_W-1:0] bcd_inc_wrap(input logic [DATE_W-1:0] v,
                                                       input logic [DATE_W-1:0] min_v,
                                                       input logic [DATE_W-1:0] max_v);
      logic [DATE_W-1:0] r;
      if (v >= max_v)
         r = min_v;
      else if (v[3:0] >= 4'd9)
         r = {v[7:4] + 4'd1, 4'd0};
      else
         r = {v[7:4], v[3:0] + 4'd1};
      return r;
   endfunction

   // Values at or below min, or above max, wrap to max.
   function automatic logic [DATE_W-1:0] bcd_dec_wrap(input logic [DATE_W-1:0] v,
                                                       input logic [DATE_W-1:0] min_v,
                                                       input logic [DATE_W-1:0] max_v);
      logic [DATE_W-1:0] r;
      if (v <= min_v || v > max_v)
         r = max_v;
      else if (v[3:0] == 4'd0)
         r = {v[7:4] - 4'd1, 4'd9};
      else
         r = {v[7:4], v[3:0] - 4'd1};
      return r;
   endfunction

endpackage

// File: rtl/date_edit_ctrl_if.sv
// Overlay/RTC-side signal bundle of the date editor.
interface date_edit_ctrl_if;
   import date_edit_pkg::*;

   logic              programar_on;
   logic              btn_up;
   logic              btn_down;
   logic              btn_left;
   logic              btn_right;
   logic [DATE_W-1:0] date_day_in;
   logic [DATE_W-1:0] date_month_in;
   logic [DATE_W-1:0] date_year_in;
   logic              write_ack;
   logic [DATE_W-1:0] fecha_day;
   logic [DATE_W-1:0] fecha_month;
   logic [DATE_W-1:0] fecha_year;
   logic [ADDR_W-1:0] direccion_actual_pantalla;
   logic              write_req;
   logic              commit_err;

   modport master (
      output programar_on, btn_up, btn_down, btn_left, btn_right,
             date_day_in, date_month_in, date_year_in, write_ack,
      input  fecha_day, fecha_month, fecha_year, direccion_actual_pantalla,
             write_req, commit_err
   );

   modport slave (
      input  programar_on, btn_up, btn_down, btn_left, btn_right,
             date_day_in, date_month_in, date_year_in, write_ack,
      output fecha_day, fecha_month, fecha_year, direccion_actual_pantalla,
             write_req, commit_err
   );
endinterface

// File: rtl/bcd_max_day.sv
// Days in a BCD month for a BCD year in 2000-2099 (leap every 4 years).
module bcd_max_day
   import date_edit_pkg::*;
(
   input  logic [DATE_W-1:0] month,
   input  logic [DATE_W-1:0] year,
   output logic [DATE_W-1:0] max_day_c
);

   logic [3:0] tens;
   logic [3:0] ones;
   logic       leap;

   assign tens = year[7:4];
   assign ones = year[3:0];

   // Divisible by 4 in BCD: even tens with ones 0/4/8, odd tens with ones 2/6.
   assign leap = (tens <= 4'd9) &&
                 ((!tens[0] && (ones == 4'd0 || ones == 4'd4 || ones == 4'd8)) ||
                  ( tens[0] && (ones == 4'd2 || ones == 4'd6)));

   always_comb begin
      max_day_c = 8'h31;
      case (month)
         8'h04, 8'h06, 8'h09, 8'h11: max_day_c = 8'h30;
         8'h02:                      max_day_c = leap ? 8'h29 : 8'h28;
         default:                    max_day_c = 8'h31;
      endcase
   end

endmodule

// File: rtl/date_edit_ctrl.sv
// Programming-mode date editor: captures RTC date, edits fields with BCD wrap, commits via req/ack.
module date_edit_ctrl
   import date_edit_pkg::*;
#(
   parameter int unsigned ACK_TIMEOUT = 1023,
   parameter int unsigned TO_W        = 10
) (
   input logic             clk,
   input logic             reset,
   date_edit_ctrl_if.slave bus
);

   state_t            state_q;
   logic [DATE_W-1:0] day_q, month_q, year_q;
   logic [ADDR_W-1:0] addr_q;
   logic              write_req_q;
   logic              commit_err_q;
   logic [TO_W-1:0]   cnt_q;

   // Sampled inputs and previous samples: {up, down, left, right}.
   logic [3:0] btn_q, btn_p;
   logic       prog_q, prog_p;

   logic up_ev, down_ev, left_ev, right_ev, prog_rise, prog_fall;
   logic inc, dec, go_next, go_prev;

   logic [DATE_W-1:0] nxt_day, nxt_month, nxt_year, max_day;
   logic [ADDR_W-1:0] nxt_addr;
   logic              my_changed;

   always_ff @(posedge clk) begin
      if (reset) begin
         btn_q  <= '0;
         btn_p  <= '0;
         prog_q <= 1'b0;
         prog_p <= 1'b0;
      end else begin
         btn_q  <= {bus.btn_up, bus.btn_down, bus.btn_left, bus.btn_right};
         btn_p  <= btn_q;
         prog_q <= bus.programar_on;
         prog_p <= prog_q;
      end
   end

   assign up_ev     = btn_q[3] & ~btn_p[3];
   assign down_ev   = btn_q[2] & ~btn_p[2];
   assign left_ev   = btn_q[1] & ~btn_p[1];
   assign right_ev  = btn_q[0] & ~btn_p[0];
   assign prog_rise = prog_q & ~prog_p;
   assign prog_fall = ~prog_q & prog_p;

   // Simultaneous opposing events cancel.
   assign inc     = up_ev & ~down_ev;
   assign dec     = down_ev & ~up_ev;
   assign go_next = right_ev & ~left_ev;
   assign go_prev = left_ev & ~right_ev;

   // Month/year edits and cursor movement; cursor acts after the value on the old field.
   always_comb begin
      nxt_month  = month_q;
      nxt_year   = year_q;
      nxt_addr   = addr_q;
      my_changed = 1'b0;
      if (addr_q == ADDR_MONTH && (inc || dec)) begin
         nxt_month  = inc ? bcd_inc_wrap(month_q, 8'h01, 8'h12)
                          : bcd_dec_wrap(month_q, 8'h01, 8'h12);
         my_changed = 1'b1;
      end
      if (addr_q == ADDR_YEAR && (inc || dec)) begin
         nxt_year   = inc ? bcd_inc_wrap(year_q, 8'h00, 8'h99)
                          : bcd_dec_wrap(year_q, 8'h00, 8'h99);
         my_changed = 1'b1;
      end
      if (go_next) begin
         case (addr_q)
            ADDR_DAY:   nxt_addr = ADDR_MONTH;
            ADDR_MONTH: nxt_addr = ADDR_YEAR;
            default:    nxt_addr = ADDR_DAY;
         endcase
      end else if (go_prev) begin
         case (addr_q)
            ADDR_DAY:  nxt_addr = ADDR_YEAR;
            ADDR_YEAR: nxt_addr = ADDR_MONTH;
            default:   nxt_addr = ADDR_DAY;
         endcase
      end
   end

   bcd_max_day u_max_day (
      .month     (nxt_month),
      .year      (nxt_year),
      .max_day_c (max_day)
   );

   // Day edit against the (unchanged) month, or clamp after a month/year change.
   always_comb begin
      nxt_day = day_q;
      if (addr_q == ADDR_DAY && inc)
         nxt_day = bcd_inc_wrap(day_q, 8'h01, max_day);
      else if (addr_q == ADDR_DAY && dec)
         nxt_day = bcd_dec_wrap(day_q, 8'h01, max_day);
      else if (my_changed && day_q > max_day)
         nxt_day = max_day;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         day_q        <= RST_DAY;
         month_q      <= RST_MONTH;
         year_q       <= RST_YEAR;
         addr_q       <= ADDR_NONE;
         write_req_q  <= 1'b0;
         commit_err_q <= 1'b0;
         cnt_q        <= '0;
      end else begin
         commit_err_q <= 1'b0;
         case (state_q)
            IDLE: begin
               day_q       <= bus.date_day_in;
               month_q     <= bus.date_month_in;
               year_q      <= bus.date_year_in;
               addr_q      <= ADDR_NONE;
               write_req_q <= 1'b0;
               if (prog_rise) begin
                  addr_q  <= ADDR_DAY;
                  state_q <= LOAD;
               end
            end
            LOAD: begin
               day_q   <= bus.date_day_in;
               month_q <= bus.date_month_in;
               year_q  <= bus.date_year_in;
               if (prog_fall) begin
                  addr_q      <= ADDR_NONE;
                  write_req_q <= 1'b1;
                  cnt_q       <= '0;
                  state_q     <= COMMIT;
               end else begin
                  addr_q  <= ADDR_DAY;
                  state_q <= EDIT;
               end
            end
            EDIT: begin
               if (prog_fall) begin
                  addr_q      <= ADDR_NONE;
                  write_req_q <= 1'b1;
                  cnt_q       <= '0;
                  state_q     <= COMMIT;
               end else begin
                  day_q   <= nxt_day;
                  month_q <= nxt_month;
                  year_q  <= nxt_year;
                  addr_q  <= nxt_addr;
               end
            end
            COMMIT: begin
               cnt_q <= cnt_q + TO_W'(1);
               if (bus.write_ack) begin
                  write_req_q <= 1'b0;
                  state_q     <= IDLE;
               end else if (cnt_q == TO_W'(ACK_TIMEOUT)) begin
                  write_req_q  <= 1'b0;
                  commit_err_q <= 1'b1;
                  state_q      <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.fecha_day                 = day_q;
   assign bus.fecha_month               = month_q;
   assign bus.fecha_year                = year_q;
   assign bus.direccion_actual_pantalla = addr_q;
   assign bus.write_req                 = write_req_q;
   assign bus.commit_err                = commit_err_q;

endmodule

// File: tb/tb_date_edit_ctrl.sv
// Scoreboard bench for date_edit_ctrl: expected outputs queued with a due cycle, compared on negedge.
module tb_date_edit_ctrl;

   logic clk = 1'b0;
   logic reset;
   int   cyc = 0;
   int   vectors = 0;
   int   miscompares = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   date_edit_ctrl_if bus();

   date_edit_ctrl #(.ACK_TIMEOUT(1023), .TO_W(10)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      string      tag;
      int         due;
      logic [7:0] d, m, y;
      logic [3:0] a;
      logic       req, err;
   } exp_t;

   exp_t sb[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic push(input string tag, input int dly, input logic [7:0] d, m, y,
                       input logic [3:0] a, input logic req, err);
      exp_t e;
      e.tag = tag; e.due = cyc + dly;
      e.d = d; e.m = m; e.y = y; e.a = a; e.req = req; e.err = err;
      sb.push_back(e);
   endtask

   always @(negedge clk) begin
      exp_t e;
      while (sb.size() > 0 && sb[0].due <= cyc) begin
         e = sb.pop_front();
         check({e.tag, ".cycle"}, cyc, e.due);
         check({e.tag, ".day"},   bus.fecha_day, e.d);
         check({e.tag, ".month"}, bus.fecha_month, e.m);
         check({e.tag, ".year"},  bus.fecha_year, e.y);
         check({e.tag, ".addr"},  bus.direccion_actual_pantalla, e.a);
         check({e.tag, ".req"},   bus.write_req, e.req);
         check({e.tag, ".err"},   bus.commit_err, e.err);
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_rtc(input logic [7:0] d, m, y);
      bus.date_day_in = d; bus.date_month_in = m; bus.date_year_in = y;
   endtask

   task automatic start_session(input string tag, input logic [7:0] d, m, y);
      set_rtc(d, m, y);
      bus.programar_on = 1'b1;
      push(tag, 2, d, m, y, 4'd3, 1'b0, 1'b0);
      tick(3);
   endtask

   // One-cycle button pulse; result is due two edges later.
   task automatic step(input string tag, input logic u, dn, l, r,
                       input logic [7:0] d, m, y, input logic [3:0] a);
      bus.btn_up = u; bus.btn_down = dn; bus.btn_left = l; bus.btn_right = r;
      push(tag, 2, d, m, y, a, 1'b0, 1'b0);
      tick(1);
      bus.btn_up = 0; bus.btn_down = 0; bus.btn_left = 0; bus.btn_right = 0;
      tick(2);
   endtask

   task automatic commit_ack(input string tag, input logic [7:0] d, m, y,
                             input logic [7:0] nd, nm, ny);
      bus.programar_on = 1'b0;
      push({tag, ".req"}, 2, d, m, y, 4'd0, 1'b1, 1'b0);
      tick(2);
      for (int i = 1; i <= 4; i++) push({tag, ".hold"}, i, d, m, y, 4'd0, 1'b1, 1'b0);
      tick(4);
      bus.write_ack = 1'b1;
      set_rtc(nd, nm, ny);
      push({tag, ".ack"}, 1, d, m, y, 4'd0, 1'b0, 1'b0);
      push({tag, ".track"}, 2, nd, nm, ny, 4'd0, 1'b0, 1'b0);
      tick(1);
      bus.write_ack = 1'b0;
      tick(2);
   endtask

   task automatic commit_timeout(input string tag, input logic [7:0] d, m, y,
                                 input logic [7:0] nd, nm, ny);
      bus.programar_on = 1'b0;
      set_rtc(nd, nm, ny);
      push({tag, ".req"},    2,    d, m, y, 4'd0, 1'b1, 1'b0);
      push({tag, ".last"},   1025, d, m, y, 4'd0, 1'b1, 1'b0);
      push({tag, ".err"},    1026, d, m, y, 4'd0, 1'b0, 1'b1);
      push({tag, ".pulse1"}, 1027, nd, nm, ny, 4'd0, 1'b0, 1'b0);
      tick(1030);
   endtask

   initial begin
      reset = 1'b1;
      bus.programar_on = 0; bus.write_ack = 0;
      bus.btn_up = 0; bus.btn_down = 0; bus.btn_left = 0; bus.btn_right = 0;
      set_rtc(8'h15, 8'h06, 8'h24);
      tick(2);
      push("reset", 0, 8'h01, 8'h01, 8'h00, 4'd0, 1'b0, 1'b0);
      tick(1);
      reset = 1'b0;
      push("idle_track", 1, 8'h15, 8'h06, 8'h24, 4'd0, 1'b0, 1'b0);
      tick(2);

      // Session 1: load and cursor movement
      start_session("load1", 8'h15, 8'h06, 8'h24);
      step("r1",      0, 0, 0, 1, 8'h15, 8'h06, 8'h24, 4'd4);
      step("r2",      0, 0, 0, 1, 8'h15, 8'h06, 8'h24, 4'd5);
      step("r3",      0, 0, 0, 1, 8'h15, 8'h06, 8'h24, 4'd3);
      step("l_3to5",  0, 0, 1, 0, 8'h15, 8'h06, 8'h24, 4'd5);
      step("l_5to4",  0, 0, 1, 0, 8'h15, 8'h06, 8'h24, 4'd4);
      step("l_4to3",  0, 0, 1, 0, 8'h15, 8'h06, 8'h24, 4'd3);
      step("updown",  1, 1, 0, 0, 8'h15, 8'h06, 8'h24, 4'd3);
      step("upright", 1, 0, 0, 1, 8'h16, 8'h06, 8'h24, 4'd4);
      step("leftright", 0, 0, 1, 1, 8'h16, 8'h06, 8'h24, 4'd4);
      commit_ack("c1", 8'h16, 8'h06, 8'h24, 8'h30, 8'h04, 8'h23);

      // Session 2: day/month wrap, clamp and leap handling
      start_session("load2", 8'h30, 8'h04, 8'h23);
      step("d_up_wrap",  1, 0, 0, 0, 8'h01, 8'h04, 8'h23, 4'd3);
      step("d_dn_wrap",  0, 1, 0, 0, 8'h30, 8'h04, 8'h23, 4'd3);
      step("to_month",   0, 0, 0, 1, 8'h30, 8'h04, 8'h23, 4'd4);
      step("m_dn_03",    0, 1, 0, 0, 8'h30, 8'h03, 8'h23, 4'd4);
      step("m_dn_clamp", 0, 1, 0, 0, 8'h28, 8'h02, 8'h23, 4'd4);
      step("m_dn_01",    0, 1, 0, 0, 8'h28, 8'h01, 8'h23, 4'd4);
      step("m_dn_wrap",  0, 1, 0, 0, 8'h28, 8'h12, 8'h23, 4'd4);
      step("m_up_wrap",  1, 0, 0, 0, 8'h28, 8'h01, 8'h23, 4'd4);
      step("to_day",     0, 0, 1, 0, 8'h28, 8'h01, 8'h23, 4'd3);
      step("d_29",       1, 0, 0, 0, 8'h29, 8'h01, 8'h23, 4'd3);
      step("d_30",       1, 0, 0, 0, 8'h30, 8'h01, 8'h23, 4'd3);
      step("d_31",       1, 0, 0, 0, 8'h31, 8'h01, 8'h23, 4'd3);
      step("to_month2",  0, 0, 0, 1, 8'h31, 8'h01, 8'h23, 4'd4);
      step("feb_23",     1, 0, 0, 0, 8'h28, 8'h02, 8'h23, 4'd4);
      step("to_year",    0, 0, 0, 1, 8'h28, 8'h02, 8'h23, 4'd5);
      step("y_24",       1, 0, 0, 0, 8'h28, 8'h02, 8'h24, 4'd5);
      step("to_month3",  0, 0, 1, 0, 8'h28, 8'h02, 8'h24, 4'd4);
      step("m_jan24",    0, 1, 0, 0, 8'h28, 8'h01, 8'h24, 4'd4);
      step("to_day2",    0, 0, 1, 0, 8'h28, 8'h01, 8'h24, 4'd3);
      step("d24_29",     1, 0, 0, 0, 8'h29, 8'h01, 8'h24, 4'd3);
      step("d24_30",     1, 0, 0, 0, 8'h30, 8'h01, 8'h24, 4'd3);
      step("d24_31",     1, 0, 0, 0, 8'h31, 8'h01, 8'h24, 4'd3);
      step("to_month4",  0, 0, 0, 1, 8'h31, 8'h01, 8'h24, 4'd4);
      step("feb_24",     1, 0, 0, 0, 8'h29, 8'h02, 8'h24, 4'd4);
      commit_ack("c2", 8'h29, 8'h02, 8'h24, 8'h29, 8'h02, 8'h00);

      // Session 3: year wrap with leap clamp, then commit timeout
      start_session("load3", 8'h29, 8'h02, 8'h00);
      step("s3_r1",      0, 0, 0, 1, 8'h29, 8'h02, 8'h00, 4'd4);
      step("s3_r2",      0, 0, 0, 1, 8'h29, 8'h02, 8'h00, 4'd5);
      step("y_dn_wrap",  0, 1, 0, 0, 8'h28, 8'h02, 8'h99, 4'd5);
      step("y_up_wrap",  1, 0, 0, 0, 8'h28, 8'h02, 8'h00, 4'd5);
      commit_timeout("c3", 8'h28, 8'h02, 8'h00, 8'h35, 8'h03, 8'h05);

      // Session 4: out-of-range capture, then reset during commit
      start_session("load4", 8'h35, 8'h03, 8'h05);
      step("oor_up",     1, 0, 0, 0, 8'h01, 8'h03, 8'h05, 4'd3);
      step("d_dn_max",   0, 1, 0, 0, 8'h31, 8'h03, 8'h05, 4'd3);
      bus.programar_on = 1'b0;
      push("c4.req", 2, 8'h31, 8'h03, 8'h05, 4'd0, 1'b1, 1'b0);
      tick(4);
      reset = 1'b1;
      push("c4.reset", 1, 8'h01, 8'h01, 8'h00, 4'd0, 1'b0, 1'b0);
      tick(1);
      reset = 1'b0;
      set_rtc(8'h12, 8'h11, 8'h10);
      push("post_reset", 1, 8'h12, 8'h11, 8'h10, 4'd0, 1'b0, 1'b0);
      tick(1);
      bus.write_ack = 1'b1;
      push("stray_ack", 1, 8'h12, 8'h11, 8'h10, 4'd0, 1'b0, 1'b0);
      tick(1);
      bus.write_ack = 1'b0;

      for (int i = 0; i < 20 && sb.size() > 0; i++) tick(1);
      check("sb_drained", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
